// File: rtl/onehot_mux_buffered.sv
// onehot_mux_buffered: N-input one-hot word multiplexer feeding a 2-entry
// valid/ready output buffer. Illegal selects (zero-hot or multi-hot) store an
// all-zero word, raise a one-cycle sel_err pulse and bump a saturating counter.
//
// Optional build macro ONEHOT_MUX_LOWEST_WINS_EN: a multi-hot select picks
// the lowest-index set channel instead of zero (still flagged as an error).
module onehot_mux_buffered #(
  parameter int NUM_IN    = 4,
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       sel,
  input  logic                    sel_valid,
  output logic                    sel_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [ERR_CNT_W-1:0]    err_count
);

  localparam int PC_W = $clog2(NUM_IN + 1);
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  // Number of set bits in a select vector.
  function automatic logic [PC_W-1:0] count_ones(input logic [NUM_IN-1:0] s);
    logic [PC_W-1:0] pc;
    pc = {PC_W{1'b0}};
    for (int i = 0; i < NUM_IN; i++) begin
      pc = pc + {{(PC_W-1){1'b0}}, s[i]};
    end
    return pc;
  endfunction

  // Word chosen by a select vector; illegal selects collapse to zero unless
  // the lowest-wins build is enabled, where multi-hot keeps the lowest channel.
  function automatic logic [WIDTH-1:0] pick_word(
    input logic [NUM_IN*WIDTH-1:0] d,
    input logic [NUM_IN-1:0]       s
  );
    logic [WIDTH-1:0] w;
    logic             found;
    w     = {WIDTH{1'b0}};
    found = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (s[i] && !found) begin
        w     = d[i*WIDTH +: WIDTH];
        found = 1'b1;
      end
    end
`ifdef ONEHOT_MUX_LOWEST_WINS_EN
    // Zero-hot never sets found, so w is already zero in that case.
`else
    if (count_ones(s) != PC_ONE) begin
      w = {WIDTH{1'b0}};
    end
`endif
    return w;
  endfunction

  // Buffer state: head_r is always the word presented on out_data.
  logic [1:0]           count_r;
  logic [WIDTH-1:0]     head_r;
  logic [WIDTH-1:0]     tail_r;
  logic                 ready_r;
  logic                 valid_r;
  logic                 err_pulse_r;
  logic [ERR_CNT_W-1:0] err_cnt_r;

  logic                 push_s;
  logic                 pop_s;
  logic                 illegal_s;
  logic [WIDTH-1:0]     word_s;
  logic [1:0]           count_nxt_s;
  logic [WIDTH-1:0]     head_nxt_s;
  logic [WIDTH-1:0]     tail_nxt_s;

  assign push_s    = sel_valid && ready_r;
  assign pop_s     = valid_r && out_ready;
  assign illegal_s = (count_ones(sel) != PC_ONE);
  assign word_s    = pick_word(in_data, sel);

  // Next buffer contents from the push/pop combination at this edge.
  always_comb begin
    count_nxt_s = count_r;
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    case (count_r)
      2'd0: begin
        if (push_s) begin
          count_nxt_s = 2'd1;
          head_nxt_s  = word_s;
        end else begin
          count_nxt_s = 2'd0;
        end
      end
      2'd1: begin
        if (push_s && pop_s) begin
          head_nxt_s = word_s;
        end else if (push_s) begin
          count_nxt_s = 2'd2;
          tail_nxt_s  = word_s;
        end else if (pop_s) begin
          count_nxt_s = 2'd0;
          head_nxt_s  = {WIDTH{1'b0}};
        end else begin
          count_nxt_s = 2'd1;
        end
      end
      2'd2: begin
        // Full: ready_r is low, so only a pop can happen here.
        if (pop_s) begin
          count_nxt_s = 2'd1;
          head_nxt_s  = tail_r;
          tail_nxt_s  = {WIDTH{1'b0}};
        end else begin
          count_nxt_s = 2'd2;
        end
      end
      default: begin
        count_nxt_s = 2'd0;
        head_nxt_s  = {WIDTH{1'b0}};
        tail_nxt_s  = {WIDTH{1'b0}};
      end
    endcase
  end

  // Buffer registers; ready/valid are registered so out_ready never reaches sel_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 2'd0;
      head_r  <= {WIDTH{1'b0}};
      tail_r  <= {WIDTH{1'b0}};
      ready_r <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      ready_r <= (count_nxt_s != 2'd2);
      valid_r <= (count_nxt_s != 2'd0);
    end
  end

  // Illegal-select pulse and saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse_r <= 1'b0;
      err_cnt_r   <= {ERR_CNT_W{1'b0}};
    end else begin
      err_pulse_r <= push_s && illegal_s;
      if (push_s && illegal_s && (err_cnt_r != ERR_MAX)) begin
        err_cnt_r <= err_cnt_r + ERR_ONE;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign sel_ready = ready_r;
  assign out_valid = valid_r;
  assign out_data  = head_r;
  assign sel_err   = err_pulse_r;
  assign err_count = err_cnt_r;

endmodule

// File: doc/onehot_mux_buffered.md
Name: onehot_mux_buffered

Overview:
- Parametrised N-input, one-hot-select word multiplexer for datapath channel selection.
- The selected word is captured into a 2-entry output buffer with valid/ready handshakes on both sides, replacing purely combinational muxing.
- Illegal selects (zero-hot or multi-hot) are flagged and counted for debug readout.

Parameters:
- NUM_IN, 4, number of input channels (>=2).
- WIDTH, 32, data word width in bits.
- ERR_CNT_W, 8, width of the saturating illegal-select counter.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  packed inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- sel  input  NUM_IN  one-hot select; bit i selects channel i.
- sel_valid  input  1  sel/in_data valid this cycle.
- sel_ready  output  1  block can accept a transfer.
- out_data  output  WIDTH  head-of-buffer word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- sel_err  output  1  one-cycle pulse, illegal select accepted last cycle.
- err_count  output  ERR_CNT_W  saturating count of accepted illegal selects.

Behaviour:
- Reset, checked on clk edge with rst=1: buffer emptied (count=0), out_valid=0, out_data=0, sel_err=0, err_count=0.
- Reset mid-operation discards buffered words. No output transfer is reported in the reset cycle.
- Push: sel_valid && sel_ready at the edge. Pop: out_valid && out_ready at the edge.
- sel_ready = (count < 2), driven from registered state only. There is no combinational path from out_ready to sel_ready.
- Latency: a word pushed at edge k appears on out_data with out_valid=1 after edge k, if the buffer was empty. Otherwise it queues behind the older word in FIFO order.
- Data selection at push:
  - popcount(sel)==1: stored word = in_data channel i.
  - popcount(sel)==0 or >1: stored word = all zeros. The transfer still completes; the word is pushed and must be popped like any other.
- sel_err=1 for exactly the cycle after an illegal-select push, else 0.
- err_count increments by 1 per illegal-select push and holds at 2^ERR_CNT_W-1; it does not wrap.
- Count transitions:
  - 0: push -> 1. out_valid=0, so no pop is possible.
  - 1: push only -> 2; pop only -> 0; push and pop -> 1, with the new word becoming head.
  - 2: sel_ready=0, so pop only -> 1. sel_valid is ignored.
- out_data is stable while out_valid=1 and out_ready=0.
- sel_valid=0: sel and in_data are ignored; no error is counted.
- Full throughput of one word per cycle is sustained when out_ready is held high.

Optional Feature:
- Macro ONEHOT_MUX_LOWEST_WINS_EN.
- Defined:
  - Multi-hot sel selects the lowest-index set bit's channel instead of zero.
  - sel_err still pulses and err_count still increments for multi-hot.
  - Zero-hot still yields all zeros plus error.
- Undefined: behaviour exactly as in Behaviour.

Test Plan:
- Reset, then legal selects: in_data channels = 0x11111111, 0x22222222, 0x33333333, 0x44444444. Push sel=0001, 0010, 0100, 1000 back-to-back with out_ready=1 -> out_data 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles, each one cycle after its push. sel_err=0, err_count=0.
- Backpressure: out_ready=0, push sel=0010 then sel=1000 -> sel_ready=0 after the second push. A third sel_valid is ignored. out_data holds 0x22222222. Raise out_ready -> 0x22222222 then 0x44444444; sel_ready returns to 1 after the first pop.
- Illegal select: push sel=0000 and sel=0110 -> two output words 0x00000000. Without the macro, both are zero. With ONEHOT_MUX_LOWEST_WINS_EN, the second word is 0x22222222. sel_err pulses each time; err_count=2.
- Saturation: ERR_CNT_W=2, push 5 illegal selects -> err_count reads 1, 2, 3, 3, 3.
- Mid-operation reset: fill the buffer to 2 with out_ready=0, assert rst for one cycle -> next cycle out_valid=0, out_data=0, sel_ready=1, err_count=0. The stale words are never emitted.
- Parameter sweep: NUM_IN=8, WIDTH=16, randomised sel_valid/out_ready -> the scoreboard matches every word in order with no loss or duplication, and the error count equals the number of illegal pushes.
